wormhole_packetizer: RTL and testbench
======================================

WORMHOLE_PACKETIZER -- requirements
Module: wormhole_packetizer

Interface
REQ-001 Parameter FLIT_DATA_W, default 8, flit payload width.
REQ-002 Parameter FLIT_ID_W, default 2, flit type field width.
REQ-003 Parameter ROW_ADDR_W, default 2, destination row address width.
REQ-004 Parameter COL_ADDR_W, default 2, destination column address width.
REQ-005 Parameter HOP_CNT_W, default 4, hop count field width.
REQ-006 Parameter LEN_W, default 4, packet length field width.
REQ-007 Port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-008 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-009 Port pkt_vld_i  input  1  packet descriptor valid.
REQ-010 Port pkt_rdy_o  output  1  descriptor accepted when pkt_vld_i and pkt_rdy_o are both high.
REQ-011 Port pkt_row_i  input  ROW_ADDR_W  destination row.
REQ-012 Port pkt_col_i  input  COL_ADDR_W  destination column.
REQ-013 Port pkt_len_i  input  LEN_W  payload flit count minus one.
REQ-014 Port pld_data_i  input  FLIT_DATA_W  payload word.
REQ-015 Port pld_vld_i  input  1  payload word valid.
REQ-016 Port pld_rdy_o  output  1  payload word accepted when pld_vld_i and pld_rdy_o are both high.
REQ-017 Port flit_o  output  FLIT_DATA_W+FLIT_ID_W  flit to router input channel; ID in MSBs, data in LSBs.
REQ-018 Port flit_vld_o  output  1  flit valid; drives router channel write enable.
REQ-019 Port flit_rdy_i  input  1  router input FIFO not full; a flit transfers when flit_vld_o and flit_rdy_i are both high.
REQ-020 Port busy_o  output  1  high while a packet is in progress.

Function
REQ-021 The block SHALL require ROW_ADDR_W+COL_ADDR_W+HOP_CNT_W <= FLIT_DATA_W; otherwise elaboration fails.
REQ-022 Flit IDs SHALL be HEAD=2'b01, BODY=2'b10, TAIL=2'b11; 2'b00 is never emitted.
REQ-023 Header data SHALL carry row in the top ROW_ADDR_W bits, then col, with hop count=0 in the LSBs and unused bits zero.
REQ-024 A packet SHALL be emitted as: HEAD, then pkt_len_i BODY flits, then one TAIL; with pkt_len_i=0 it is HEAD then TAIL.
REQ-025 Body and tail flits SHALL carry the payload words unmodified, in order of acceptance.
REQ-026 FSM states: IDLE, HEAD, PAYLOAD; DRAIN is optional.
REQ-027 IDLE: pkt_rdy_o=1; on descriptor accept, latch row, col and len into the remaining counter, then go to HEAD.
REQ-028 HEAD: load the header into the output register, assert flit_vld_o the cycle after accept, then go to PAYLOAD.
REQ-029 PAYLOAD: pld_rdy_o = !flit_vld_o || flit_rdy_i; each accepted word loads the output register next cycle.
REQ-030 Each accepted word SHALL be tagged BODY while remaining≠0 (remaining then decrements); at remaining=0 it is tagged TAIL.
REQ-031 After the TAIL is accepted by the router, the FSM SHALL return to IDLE.
REQ-032 flit_o and flit_vld_o SHALL be registered and held stable while flit_vld_o=1 and flit_rdy_i=0.
REQ-033 In steady state the block SHALL sustain one flit per cycle while pld_vld_i and flit_rdy_i stay high.
REQ-034 pkt_rdy_o SHALL be 0 outside IDLE, so there is at most one packet in flight.
REQ-035 The next descriptor SHALL be accepted no earlier than the cycle after the TAIL transfers.
REQ-036 pld_rdy_o SHALL be 0 in IDLE and HEAD.
REQ-037 busy_o = (state≠IDLE) || flit_vld_o.

Reset
REQ-038 While rst_i=1, state=IDLE, the counter is 0 and flit_o=0.
REQ-039 While rst_i=1, flit_vld_o=0, pld_rdy_o=0, pkt_rdy_o=0 and busy_o=0.
REQ-040 Reset asserted mid-packet SHALL drop the packet immediately; no TAIL is emitted.
REQ-041 pkt_rdy_o SHALL rise in the first cycle after rst_i deasserts.

Verification
REQ-042 Descriptor row=2, col=3, len=2, payload 0xA1/0xA2/0xA3, flit_rdy_i=1 -> flits 0x1B0 (HEAD), 0x2A1 (BODY), 0x2A2 (BODY), 0x3A3 (TAIL) in 4 consecutive cycles.
REQ-043 len=0, payload 0x55 -> HEAD then TAIL 0x355 only; pkt_rdy_o=1 the cycle after the TAIL transfer.
REQ-044 flit_rdy_i held 0 for 3 cycles during BODY -> flit_o stable, pld_rdy_o=0 while the register is full; no flit lost or duplicated.
REQ-045 pld_vld_i gapped (1-0-1-0) -> flit_vld_o gaps match; order preserved; TAIL tagged on the last word only.
REQ-046 rst_i pulsed after the HEAD transfer -> flit_vld_o=0 immediately, IDLE after release, and a new packet emits correctly.
REQ-047 Back-to-back descriptors held valid -> second HEAD follows first TAIL with exactly one idle cycle.

Source files
------------

// File: rtl/wormhole_packetizer.sv
// Wormhole packetizer: turns a descriptor plus a stream of payload words into
// HEAD / BODY... / TAIL flits for a router input channel.
module wormhole_packetizer #(
    parameter int FLIT_DATA_W = 8,
    parameter int FLIT_ID_W   = 2,
    parameter int ROW_ADDR_W  = 2,
    parameter int COL_ADDR_W  = 2,
    parameter int HOP_CNT_W   = 4,
    parameter int LEN_W       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           pkt_vld_i,
    output logic                           pkt_rdy_o,
    input  logic [ROW_ADDR_W-1:0]          pkt_row_i,
    input  logic [COL_ADDR_W-1:0]          pkt_col_i,
    input  logic [LEN_W-1:0]               pkt_len_i,
    input  logic [FLIT_DATA_W-1:0]         pld_data_i,
    input  logic                           pld_vld_i,
    output logic                           pld_rdy_o,
    output logic [FLIT_DATA_W+FLIT_ID_W-1:0] flit_o,
    output logic                           flit_vld_o,
    input  logic                           flit_rdy_i,
    output logic                           busy_o
);

    // Hop count (always zero at injection) and unused bits share the header LSBs.
    localparam int PAD_W = FLIT_DATA_W - ROW_ADDR_W - COL_ADDR_W;

    localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

    if (ROW_ADDR_W + COL_ADDR_W + HOP_CNT_W > FLIT_DATA_W) begin : g_bad_cfg
        $error("wormhole_packetizer: header fields do not fit in FLIT_DATA_W");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEAD    = 2'd1,
        S_PAYLOAD = 2'd2
    } state_e;

    state_e                           state_q;
    logic [ROW_ADDR_W-1:0]            row_q;
    logic [COL_ADDR_W-1:0]            col_q;
    logic [LEN_W-1:0]                 rem_q;
    logic                             last_q;
    logic [FLIT_DATA_W+FLIT_ID_W-1:0] flit_q;
    logic                             flit_vld_q;

    logic pkt_acc;
    logic pld_acc;
    logic flit_xfer;

    assign pkt_rdy_o  = (state_q == S_IDLE) && !rst_i;
    assign pkt_acc    = pkt_vld_i && pkt_rdy_o;
    assign flit_xfer  = flit_vld_q && flit_rdy_i;
    // last_q stops intake once the TAIL word sits in the output register.
    assign pld_rdy_o  = (state_q == S_PAYLOAD) && !last_q && (!flit_vld_q || flit_rdy_i);
    assign pld_acc    = pld_vld_i && pld_rdy_o;
    assign flit_o     = flit_q;
    assign flit_vld_o = flit_vld_q;
    assign busy_o     = (state_q != S_IDLE) || flit_vld_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rem_q      <= '0;
            last_q     <= 1'b0;
            flit_q     <= '0;
            flit_vld_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pkt_acc) begin
                        row_q   <= pkt_row_i;
                        col_q   <= pkt_col_i;
                        rem_q   <= pkt_len_i;
                        last_q  <= 1'b0;
                        state_q <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    flit_q     <= {ID_HEAD, row_q, col_q, {PAD_W{1'b0}}};
                    flit_vld_q <= 1'b1;
                    state_q    <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (pld_acc) begin
                        flit_q     <= {(rem_q == '0) ? ID_TAIL : ID_BODY, pld_data_i};
                        flit_vld_q <= 1'b1;
                        if (rem_q != '0) begin
                            rem_q <= rem_q - LEN_W'(1);
                        end else begin
                            last_q <= 1'b1;
                        end
                    end else if (flit_xfer) begin
                        flit_vld_q <= 1'b0;
                        if (last_q) begin
                            last_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wormhole_packetizer.sv
// Randomized bench for wormhole_packetizer: a packet-level model predicts the
// flit stream and handshake levels; directed phases cover the corner cases.
module tb_wormhole_packetizer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       pkt_vld_i, pkt_rdy_o;
    logic [1:0] pkt_row_i, pkt_col_i;
    logic [3:0] pkt_len_i;
    logic [7:0] pld_data_i;
    logic       pld_vld_i, pld_rdy_o;
    logic [9:0] flit_o;
    logic       flit_vld_o, flit_rdy_i, busy_o;

    wormhole_packetizer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pkt_vld_i(pkt_vld_i), .pkt_rdy_o(pkt_rdy_o),
        .pkt_row_i(pkt_row_i), .pkt_col_i(pkt_col_i), .pkt_len_i(pkt_len_i),
        .pld_data_i(pld_data_i), .pld_vld_i(pld_vld_i), .pld_rdy_o(pld_rdy_o),
        .flit_o(flit_o), .flit_vld_o(flit_vld_o), .flit_rdy_i(flit_rdy_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model
    logic [9:0] exp_q[$];
    logic [9:0] xlog[$];
    int         xcyc[$];
    bit         in_pkt, hdr_sent, prev_stall, hold_chk, expect_b2b;
    logic [9:0] prev_flit;
    int         words_left, ncyc, acc_cyc, tail_cyc;

    // stimulus state
    bit         desc_pend, word_pend, pld_alt, alt_ph;
    logic [1:0] d_row, d_col;
    logic [3:0] d_len;
    logic [7:0] cur_word;
    logic [7:0] dir_words[$];
    int         p_pkt, p_pld, p_rdy, stall_cnt;

    function automatic logic [9:0] head_flit(input logic [1:0] r, input logic [1:0] c);
        return {2'b01, r, c, 4'b0000};
    endfunction

    task automatic observe();
        logic [9:0] e;
        bit exp_pr;
        ncyc++;
        if (rst_i) begin
            chk("rst_flit_vld", flit_vld_o, 0);
            chk("rst_pkt_rdy", pkt_rdy_o, 0);
            chk("rst_pld_rdy", pld_rdy_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_flit", flit_o, 0);
            exp_q.delete();
            in_pkt = 0; hdr_sent = 0; words_left = 0; prev_stall = 0; expect_b2b = 0;
            return;
        end
        chk("busy", busy_o, in_pkt);
        chk("pkt_rdy", pkt_rdy_o, !in_pkt);
        if (!in_pkt) chk("idle_flit_vld", flit_vld_o, 0);
        if (in_pkt && ncyc == acc_cyc + 2) chk("head_latency", flit_vld_o, 1);
        if (prev_stall) begin
            chk("hold_vld", flit_vld_o, 1);
            chk("hold_flit", flit_o, prev_flit);
        end
        exp_pr = in_pkt && words_left > 0 && (flit_vld_o ? flit_rdy_i : hdr_sent);
        chk("pld_rdy", pld_rdy_o, exp_pr);

        if (flit_vld_o && flit_rdy_i) begin
            xlog.push_back(flit_o);
            xcyc.push_back(ncyc);
            if (exp_q.size() == 0) begin
                chk("extra_flit", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("flit", flit_o, e);
                if (e[9:8] == 2'b01) hdr_sent = 1;
                if (e[9:8] == 2'b11) begin
                    in_pkt = 0;
                    tail_cyc = ncyc;
                    if (hold_chk) expect_b2b = 1;
                end
            end
        end
        prev_stall = flit_vld_o && !flit_rdy_i;
        prev_flit = flit_o;

        if (pkt_vld_i && pkt_rdy_o) begin
            if (expect_b2b) chk("b2b_accept_gap", ncyc - tail_cyc, 1);
            expect_b2b = 0;
            exp_q.push_back(head_flit(pkt_row_i, pkt_col_i));
            words_left = int'(pkt_len_i) + 1;
            in_pkt = 1; hdr_sent = 0;
            acc_cyc = ncyc;
            desc_pend = 0;
        end
        if (pld_vld_i && pld_rdy_o) begin
            chk("pld_overrun", words_left > 0, 1);
            exp_q.push_back({(words_left == 1) ? 2'b11 : 2'b10, pld_data_i});
            if (words_left > 0) words_left--;
            word_pend = 0;
        end
    endtask

    task automatic drive();
        if (!desc_pend && $urandom_range(99) < p_pkt) begin
            desc_pend = 1;
            d_row = 2'($urandom);
            d_col = 2'($urandom);
            d_len = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
        end
        pkt_vld_i = desc_pend;
        pkt_row_i = d_row;
        pkt_col_i = d_col;
        pkt_len_i = d_len;
        if (!word_pend) begin
            word_pend = 1;
            cur_word = (dir_words.size() > 0) ? dir_words.pop_front() : 8'($urandom);
        end
        pld_data_i = cur_word;
        if (pld_alt) begin
            alt_ph = !alt_ph;
            pld_vld_i = alt_ph;
        end else begin
            pld_vld_i = $urandom_range(99) < p_pld;
        end
        if (stall_cnt > 0) begin
            flit_rdy_i = 0;
            stall_cnt--;
        end else begin
            flit_rdy_i = $urandom_range(99) < p_rdy;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        observe();
        @(posedge clk_i);
        #1;
        drive();
    endtask

    task automatic apply_reset(input int n);
        rst_i = 1;
        repeat (n) step();
        rst_i = 0;
    endtask

    task automatic run_until_log(input int target, input int budget);
        int k = 0;
        while (xlog.size() < target && k < budget) begin
            step();
            k++;
        end
        chk("timeout_flits", xlog.size() >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((in_pkt || desc_pend || exp_q.size() > 0) && k < budget) begin
            step();
            k++;
        end
        chk("timeout_idle", in_pkt || desc_pend || exp_q.size() > 0, 0);
    endtask

    task automatic start_pkt(input logic [1:0] r, input logic [1:0] c, input logic [3:0] l);
        d_row = r; d_col = c; d_len = l;
        desc_pend = 1;
        word_pend = 0;
        drive();
    endtask

    int base;

    initial begin
        rst_i = 1;
        pkt_vld_i = 0; pkt_row_i = 0; pkt_col_i = 0; pkt_len_i = 0;
        pld_data_i = 0; pld_vld_i = 0; flit_rdy_i = 0;
        p_pkt = 0; p_pld = 0; p_rdy = 100; stall_cnt = 0;
        desc_pend = 0; word_pend = 0; pld_alt = 0; alt_ph = 0; hold_chk = 0;
        ncyc = 0; acc_cyc = -10; tail_cyc = -10;
        apply_reset(3);
        step();
        chk("pkt_rdy_after_rst", pkt_rdy_o, 1);

        // basic packet at full rate
        p_pld = 100;
        dir_words = '{8'hA1, 8'hA2, 8'hA3};
        base = xlog.size();
        start_pkt(2'd2, 2'd3, 4'd2);
        run_until_log(base + 4, 20);
        chk("d1_head", xlog[base], 10'h1B0);
        chk("d1_body0", xlog[base+1], 10'h2A1);
        chk("d1_body1", xlog[base+2], 10'h2A2);
        chk("d1_tail", xlog[base+3], 10'h3A3);
        chk("d1_consecutive", xcyc[base+3] - xcyc[base], 3);
        wait_idle(20);

        // zero-length payload
        dir_words = '{8'h55};
        base = xlog.size();
        start_pkt(2'd1, 2'd0, 4'd0);
        run_until_log(base + 2, 20);
        chk("d2_head", xlog[base], 10'h140);
        chk("d2_tail", xlog[base+1], 10'h355);
        step();
        chk("d2_pkt_rdy_after_tail", pkt_rdy_o, 1);
        wait_idle(20);

        // router back-pressure for three cycles during the body
        dir_words = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        base = xlog.size();
        start_pkt(2'd0, 2'd1, 4'd3);
        run_until_log(base + 2, 20);
        stall_cnt = 3;
        drive();
        run_until_log(base + 5, 30);
        chk("d3_body1", xlog[base+2], 10'h2B2);
        chk("d3_body2", xlog[base+3], 10'h2B3);
        chk("d3_tail", xlog[base+4], 10'h3B4);
        chk("d3_stall_gap", xcyc[base+2] - xcyc[base+1], 4);
        wait_idle(20);

        // gapped payload
        pld_alt = 1;
        dir_words = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        base = xlog.size();
        start_pkt(2'd3, 2'd2, 4'd3);
        run_until_log(base + 5, 40);
        chk("d4_gap", xcyc[base+2] - xcyc[base+1], 2);
        chk("d4_tail", xlog[base+4], 10'h3C4);
        pld_alt = 0;
        wait_idle(20);

        // reset mid-packet after the HEAD has gone
        p_pld = 0;
        base = xlog.size();
        start_pkt(2'd1, 2'd1, 4'd3);
        run_until_log(base + 1, 20);
        apply_reset(2);
        desc_pend = 0;
        step();
        chk("d5_pkt_rdy_after_rst", pkt_rdy_o, 1);
        p_pld = 100;
        dir_words = '{8'hD1, 8'hD2};
        base = xlog.size();
        start_pkt(2'd3, 2'd1, 4'd1);
        run_until_log(base + 3, 20);
        chk("d5_head", xlog[base], 10'h1D0);
        chk("d5_body", xlog[base+1], 10'h2D1);
        chk("d5_tail", xlog[base+2], 10'h3D2);
        wait_idle(20);

        // back-to-back descriptors held valid
        p_pkt = 100; hold_chk = 1;
        repeat (80) step();
        p_pkt = 0; hold_chk = 0; expect_b2b = 0;
        wait_idle(100);

        // random traffic
        p_pkt = 30; p_pld = 70; p_rdy = 60;
        repeat (3000) step();
        p_pkt = 0; p_pld = 100; p_rdy = 100;
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
